// File: rtl/manifold_beam_sequencer.sv
// Streaming beam-splitter sequencer: consumes one map row per handshake, propagates the beam
// vector and accumulates a saturating split count. Optional abort input under MANIFOLD_ABORT_EN.
module manifold_beam_sequencer #(
  parameter int WIDTH     = 141,
  parameter int HEIGHT    = 141,
  parameter int START_COL = 70,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef MANIFOLD_ABORT_EN
  input  logic             abort,
`endif
  input  logic             row_valid,
  output logic             row_ready,
  input  logic [WIDTH-1:0] row_data,
  output logic             busy,
  output logic             finished,
  output logic [CNT_W-1:0] result,
  output logic [WIDTH-1:0] beam_out
);

  localparam int PC_W = $clog2(WIDTH + 1);
  localparam int RC_W = (HEIGHT > 2) ? $clog2(HEIGHT) : 1;
  localparam int SW   = CNT_W + PC_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [WIDTH-1:0] BEAM_SEED = {{(WIDTH-1){1'b0}}, 1'b1} << START_COL;
  localparam logic [RC_W-1:0]  LAST_ROW  = RC_W'(HEIGHT - 2);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic [PC_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [PC_W-1:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) begin
      n = n + PC_W'(v[i]);
    end
    return n;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [PC_W-1:0]  b);
    logic [SW-1:0] s;
    s = SW'(a) + SW'(b);
    if (s > SW'(CNT_MAX)) begin
      return CNT_MAX;
    end else begin
      return s[CNT_W-1:0];
    end
  endfunction

  state_e           state_q;
  logic [WIDTH-1:0] beam_q;
  logic [WIDTH-1:0] hits_q;
  logic [CNT_W-1:0] sum_q;
  logic [CNT_W-1:0] result_q;
  logic             finished_q;
  logic [RC_W-1:0]  row_cnt_q;

  logic             abort_req;
  logic             handshake;
  logic [WIDTH-1:0] hits_d;
  logic [WIDTH-1:0] beam_d;
  logic [CNT_W-1:0] acc_d;

`ifdef MANIFOLD_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign row_ready = (state_q == ST_RUN);
  assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign handshake = row_valid & row_ready;

  // A split sends the beam to both neighbours; shifts naturally drop beams leaving the edges.
  assign hits_d = beam_q & row_data;
  assign beam_d = (beam_q & ~row_data) | (hits_d << 1) | (hits_d >> 1);
  assign acc_d  = sat_add(sum_q, popcount(hits_q));

  assign finished = finished_q;
  assign result   = result_q;
  assign beam_out = beam_q;

  // Sequencer FSM and datapath registers; split counts are folded in one cycle after the row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      beam_q     <= '0;
      hits_q     <= '0;
      sum_q      <= '0;
      result_q   <= '0;
      finished_q <= 1'b0;
      row_cnt_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start && !abort_req) begin
            beam_q     <= BEAM_SEED;
            row_cnt_q  <= '0;
            sum_q      <= '0;
            hits_q     <= '0;
            finished_q <= 1'b0;
            state_q    <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (abort_req) begin
            hits_q  <= '0;
            state_q <= ST_IDLE;
          end else begin
            sum_q <= acc_d;
            if (handshake) begin
              hits_q    <= hits_d;
              beam_q    <= beam_d;
              row_cnt_q <= row_cnt_q + RC_W'(1);
              if (row_cnt_q == LAST_ROW) begin
                state_q <= ST_DRAIN;
              end
            end else begin
              hits_q <= '0;
            end
          end
        end
        ST_DRAIN: begin
          hits_q <= '0;
          if (abort_req) begin
            state_q <= ST_IDLE;
          end else begin
            result_q   <= acc_d;
            finished_q <= 1'b1;
            state_q    <= ST_DONE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_manifold_beam_sequencer.sv
// Scoreboard bench: two sequencer configurations run in lockstep against a column-by-column
// reference model; a monitor pops expected results whenever finished rises.
module tb_manifold_beam_sequencer;

  localparam int W = 5;

  logic clk, rst_n, start, row_valid;
  logic [W-1:0] row_data;
`ifdef MANIFOLD_ABORT_EN
  logic abort;
`endif
  logic rr_a, busy_a, fin_a, rr_b, busy_b, fin_b;
  logic [7:0] res_a;
  logic [1:0] res_b;
  logic [W-1:0] beam_a, beam_b;

  int checks = 0;
  int failures = 0;

  typedef struct { int res; logic [W-1:0] beam; } exp_t;
  exp_t q_a[$];
  exp_t q_b[$];
  logic [W-1:0] rows_v [3];

  manifold_beam_sequencer #(.WIDTH(W), .HEIGHT(4), .START_COL(2), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start),
`ifdef MANIFOLD_ABORT_EN
    .abort(abort),
`endif
    .row_valid(row_valid), .row_ready(rr_a), .row_data(row_data),
    .busy(busy_a), .finished(fin_a), .result(res_a), .beam_out(beam_a));

  manifold_beam_sequencer #(.WIDTH(W), .HEIGHT(4), .START_COL(0), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start),
`ifdef MANIFOLD_ABORT_EN
    .abort(abort),
`endif
    .row_valid(row_valid), .row_ready(rr_b), .row_data(row_data),
    .busy(busy_b), .finished(fin_b), .result(res_b), .beam_out(beam_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Reference: walk the columns, each lit column either splits to its in-range neighbours or passes.
  function automatic void model(input int sc, input int cw, output int res, output logic [W-1:0] beam);
    int b [W];
    int nb [W];
    int total;
    int cap;
    total = 0;
    for (int c = 0; c < W; c++) b[c] = (c == sc) ? 1 : 0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < W; c++) nb[c] = 0;
      for (int c = 0; c < W; c++) begin
        if (b[c] != 0) begin
          if (rows_v[r][c]) begin
            total++;
            if (c > 0) nb[c-1] = 1;
            if (c < W - 1) nb[c+1] = 1;
          end else begin
            nb[c] = 1;
          end
        end
      end
      for (int c = 0; c < W; c++) b[c] = nb[c];
    end
    cap = (1 << cw) - 1;
    res = (total > cap) ? cap : total;
    for (int c = 0; c < W; c++) beam[c] = (b[c] != 0);
  endfunction

  initial begin : monitor
    logic pa, pb;
    exp_t e;
    pa = 1'b0;
    pb = 1'b0;
    forever begin
      @(negedge clk);
      if (fin_a && !pa) begin
        if (q_a.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_finish_a actual=1 expected=0");
        end else begin
          e = q_a.pop_front();
          chk("result_a", 32'(res_a), e.res);
          chk("beam_a", 32'(beam_a), 32'(e.beam));
        end
      end
      if (fin_b && !pb) begin
        if (q_b.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_finish_b actual=1 expected=0");
        end else begin
          e = q_b.pop_front();
          chk("result_b", 32'(res_b), e.res);
          chk("beam_b", 32'(beam_b), 32'(e.beam));
        end
      end
      pa = fin_a;
      pb = fin_b;
    end
  end

  task automatic send_row(input logic [W-1:0] d, input bit gaps);
    int g;
    g = gaps ? int'($urandom_range(0, 2)) : 0;
    row_valid = 1'b0;
    repeat (g) begin
      chk("ready_in_stall", 32'(rr_a), 1);
      @(negedge clk);
    end
    row_valid = 1'b1;
    row_data  = d;
    start     = gaps && ($urandom_range(0, 2) == 0);
    chk("ready_in_run", 32'(rr_a & rr_b), 1);
    @(negedge clk);
    row_valid = 1'b0;
    start     = 1'b0;
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_out_a"}, 32'({rr_a, busy_a, fin_a, res_a, beam_a}), 0);
    chk({nm, "_out_b"}, 32'({rr_b, busy_b, fin_b, res_b, beam_b}), 0);
  endtask

  task automatic do_run(input bit gaps);
    exp_t e;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("run_busy", 32'(busy_a), 1);
    chk("run_finished_low", 32'(fin_a | fin_b), 0);
    model(2, 8, e.res, e.beam);
    q_a.push_back(e);
    model(0, 2, e.res, e.beam);
    q_b.push_back(e);
    for (int r = 0; r < 3; r++) send_row(rows_v[r], gaps);
    chk("drain_finished_low", 32'(fin_a), 0);
    chk("drain_busy", 32'(busy_a), 1);
    chk("drain_ready_low", 32'(rr_a), 0);
    @(negedge clk);
    chk("finish_latency", 32'(fin_a & fin_b), 1);
    chk("done_busy_low", 32'(busy_a), 0);
  endtask

  task automatic set_rows(input logic [W-1:0] r0, input logic [W-1:0] r1, input logic [W-1:0] r2);
    rows_v[0] = r0;
    rows_v[1] = r1;
    rows_v[2] = r2;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin : stimulus
    logic [7:0] held;
    rst_n = 1'b0; start = 1'b0; row_valid = 1'b0; row_data = '0;
`ifdef MANIFOLD_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    set_rows(5'b00100, 5'b01010, 5'b00000);
    do_run(1'b0);
    chk("basic_result", 32'(res_a), 3);
    chk("basic_beam", 32'(beam_a), 32'(5'b10101));

    held = res_a;
    repeat (2) begin
      row_valid = 1'b1;
      row_data  = W'($urandom);
      @(negedge clk);
      chk("done_ready_low", 32'(rr_a), 0);
      chk("done_hold", 32'({fin_a, res_a}), 32'({1'b1, held}));
    end
    row_valid = 1'b0;

    set_rows(5'b00001, 5'b00000, 5'b00000);
    do_run(1'b0);
    chk("edge_loss_result", 32'(res_b), 1);
    chk("edge_loss_beam", 32'(beam_b), 32'(5'b00010));

    set_rows(5'b00100, 5'b01010, 5'b00000);
    do_run(1'b1);
    chk("stall_result", 32'(res_a), 3);

    set_rows(5'b11111, 5'b11111, 5'b11111);
    do_run(1'b0);
    chk("sat_result", 32'(res_b), 3);
    chk("full_result_a", 32'(res_a), 6);

    for (int n = 0; n < 20; n++) begin
      set_rows(W'($urandom), W'($urandom), W'($urandom));
      do_run(1'b1);
    end

    set_rows(5'b00100, 5'b01010, 5'b00000);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_row(rows_v[0], 1'b0);
    send_row(rows_v[1], 1'b0);
    rst_n = 1'b0;
    #1;
    check_zero("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_run(1'b0);
    chk("after_reset_result", 32'(res_a), 3);

`ifdef MANIFOLD_ABORT_EN
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_row(rows_v[0], 1'b0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_state", 32'({busy_a, fin_a}), 0);
    chk("abort_result", 32'(res_a), 3);
    do_run(1'b0);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("abort_start_done", 32'({busy_a, fin_a}), 32'(2'b01));
`endif

    repeat (3) @(negedge clk);
    chk("queue_a_empty", 32'(q_a.size()), 0);
    chk("queue_b_empty", 32'(q_b.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
